mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Upstream sequencer for the parameterized n:1 select mux. It accepts an n-bit word over a valid/ready handshake and registers it onto the mux data inputs. It then steps the mux select from 0 to n-1, holding each value for a programmable number of cycles, so the mux output streams the word LSB-first. It flags which cycles carry a valid mux output, marks the last bit, and pulses done when the scan completes.

## Interface
- n, 4: word width and mux input count; n >= 2, need not be a power of two.
- hold, 1: cycles each select value is held; hold >= 1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- din  in  n  word to scan.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a word this cycle.
- i  out  n  registered word; drives the mux data inputs.
- s  out  $clog2(n)  registered select; drives the mux select.
- sv  out  1  select valid; mux output is meaningful this cycle.
- last  out  1  sv and s == n-1.
- done  out  1  one-cycle pulse, registered, the cycle after the final scan cycle.

## Operation
- Two states: IDLE and SCAN.
- Reset values: state IDLE; i = 0, s = 0, sv = 0, last = 0, done = 0, hold counter = 0; din_ready = 0 while rst is high.
- Final cycle: state SCAN, s == n-1 and hold counter == hold-1.
- din_ready (combinational) = !rst && (IDLE || final cycle).
- Accept occurs when din_valid && din_ready at a rising edge:
  - i <= din, s <= 0, hold counter <= 0, state <= SCAN.
- In SCAN, sv = 1 and the hold counter increments each cycle.
  - When the counter reaches hold-1, it clears and s increments.
  - At the final cycle, with no accept, the next state is IDLE, sv drops and s returns to 0.
- Back-to-back: an accept in the final cycle reloads i, sets s = 0 and stays in SCAN. There is no bubble; done still pulses for the completed word.
- din and din_valid are ignored in any SCAN cycle other than the final one. Upstream must hold them.
- s never exceeds n-1, so the mux out-of-range path is never exercised.
  - Example: n = 3 gives a 2-bit s that wraps 2 -> 0 on reload, never 3.
- i is stable throughout a scan and is cleared only by reset.
- Reset mid-scan aborts immediately (asynchronous): outputs return to reset values and no done is issued for the aborted word.

## Timing
- Accept at edge k: at cycle k+1, sv = 1 and s = 0.
- Scan length: n*hold cycles.
- s = j spans cycles k+1+j*hold to k+(j+1)*hold.
- last is high for the final hold cycles.
- done is high for exactly one cycle, at cycle k+n*hold+1.
- din_ready is high in that same cycle if idle, and also in the final scan cycle.
- Sustained throughput is one word per n*hold cycles.
- Mux output y is combinational from i and s; the consumer samples y when sv = 1.

## Structure
- Shared package mux_scan_pkg holds:
  - typedef enum scan_state_t {IDLE, SCAN};
  - localparam helper for select width, $clog2(n).
- No sub-module required.
  - Hold counter and select counter live in this module.
  - The mux is instantiated alongside by the parent, not inside this block.

## Test plan
- n=4, hold=1, din=4'b1001 accepted at cycle 0:
  - s = 0,1,2,3 on cycles 1-4, sv = 1, mux y = 1,0,0,1.
  - last on cycle 4, done on cycle 5.
  - din_ready high on cycles 0, 4 and 5.
- n=4, hold=2, din=4'b0110:
  - each s held 2 cycles over cycles 1-8, y = 0,0,1,1,1,1,0,0.
  - last on cycles 7-8, done on cycle 9.
- Back-to-back, n=4, hold=1: words 4'b1010 then 4'b0101, second accepted in cycle 4:
  - sv continuous across cycles 1-8, s goes 3 -> 0 at cycle 5.
  - done on cycles 5 and 9.
- n=3, hold=1, din=3'b101: s = 0,1,2 only, never 3; y = 1,0,1.
- din_valid toggled with din=4'hF during cycles 1-3 of a scan of 4'h0: ignored, i stays 0, y = 0 throughout.
- rst asserted mid-scan at s=2: same-cycle i = 0, s = 0, sv = 0, no done; after release, din_ready = 1 and a new word scans normally.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizing helpers for the mux scan controller.
package mux_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Counter width for a range of `count` values; never narrower than one bit.
  function automatic int sel_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word handshake and mux-drive bundle between upstream, the scan controller and the mux.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int n = 4
);
  localparam int SW = sel_width(n);

  logic [n-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [n-1:0]  i;
  logic [SW-1:0] s;
  logic          sv;
  logic          last;
  logic          done;

  modport master (
    output din, din_valid,
    input  din_ready, i, s, sv, last, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, i, s, sv, last, done
  );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Accepts an n-bit word and steps the downstream mux select 0..n-1, holding each
// value for `hold` cycles, so the mux output streams the word LSB-first.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int n    = 4,
  parameter int hold = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  localparam int SW = sel_width(n);
  localparam int HW = sel_width(hold);
  localparam logic [SW-1:0] S_LAST = SW'(n - 1);
  localparam logic [HW-1:0] H_LAST = HW'(hold - 1);

  scan_state_t   state_r, state_s;
  logic [n-1:0]  i_r, i_s;
  logic [SW-1:0] s_r, s_s;
  logic [HW-1:0] cnt_r, cnt_s;
  logic          done_r, done_s;
  logic          scan_s, final_s, ready_s, accept_s;

  // The final scan cycle doubles as an accept slot so back-to-back words have no bubble.
  always_comb begin
    scan_s   = (state_r == SCAN);
    final_s  = scan_s && (s_r == S_LAST) && (cnt_r == H_LAST);
    ready_s  = !rst && (!scan_s || final_s);
    accept_s = bus.din_valid && ready_s;
  end

  // Next-state and next-register values.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    s_s     = s_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SCAN;
          i_s     = bus.din;
          s_s     = {SW{1'b0}};
          cnt_s   = {HW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (final_s) begin
          done_s = 1'b1;
          s_s    = {SW{1'b0}};
          cnt_s  = {HW{1'b0}};
          if (accept_s) begin
            state_s = SCAN;
            i_s     = bus.din;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r == H_LAST) begin
          cnt_s = {HW{1'b0}};
          s_s   = s_r + SW'(1'b1);
        end else begin
          cnt_s = cnt_r + HW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        s_s     = {SW{1'b0}};
        cnt_s   = {HW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts a scan without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      i_r     <= {n{1'b0}};
      s_r     <= {SW{1'b0}};
      cnt_r   <= {HW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      s_r     <= s_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  assign bus.din_ready = ready_s;
  assign bus.i         = i_r;
  assign bus.s         = s_r;
  assign bus.sv        = scan_s;
  assign bus.last      = scan_s && (s_r == S_LAST);
  assign bus.done      = done_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: cycle tables, hand sequences, and a random run against an elapsed-time model.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_ctrl_if #(.n(4)) bus_a ();
  mux_scan_ctrl_if #(.n(4)) bus_b ();
  mux_scan_ctrl_if #(.n(3)) bus_c ();

  mux_scan_ctrl #(.n(4), .hold(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_scan_ctrl #(.n(4), .hold(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mux_scan_ctrl #(.n(3), .hold(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic y4(input logic [3:0] w, input logic [1:0] sel);
    return w[sel];
  endfunction

  function automatic logic y3(input logic [2:0] w, input logic [1:0] sel);
    logic r;
    r = 1'b0;
    if (sel < 2'd3) r = w[sel];
    return r;
  endfunction

  typedef struct {
    logic [3:0] din;
    logic       vld;
    logic [3:0] i;
    logic [1:0] s;
    logic       sv;
    logic       last;
    logic       rdy;
    logic       done;
    logic       y;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] din, input logic vld, input logic [3:0] i,
                              input logic [1:0] s, input logic sv, input logic last,
                              input logic rdy, input logic done, input logic y);
    vec_t v;
    v.din = din; v.vld = vld; v.i = i; v.s = s; v.sv = sv;
    v.last = last; v.rdy = rdy; v.done = done; v.y = y;
    return v;
  endfunction

  vec_t tab_a[16];
  vec_t tab_b[20];

  // random-run model for dut_b: elapsed cycles since the current word was accepted
  localparam int NB = 4;
  localparam int HB = 2;
  bit         m_busy;
  int         m_t;
  logic [3:0] m_word;
  bit         m_done;

  initial begin
    bus_a.din = 4'd0; bus_a.din_valid = 1'b0;
    bus_b.din = 4'd0; bus_b.din_valid = 1'b0;
    bus_c.din = 3'd0; bus_c.din_valid = 1'b0;

    // n=4 hold=1: word 1001, then 1010 and 0101 back-to-back
    //               din    vld   i       s     sv    last  rdy   done  y
    tab_a[0]  = mk(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab_a[1]  = mk(4'b0000, 1'b0, 4'b1001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_a[2]  = mk(4'b0000, 1'b0, 4'b1001, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_a[3]  = mk(4'b0000, 1'b0, 4'b1001, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_a[4]  = mk(4'b0000, 1'b0, 4'b1001, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tab_a[5]  = mk(4'b1010, 1'b1, 4'b1001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tab_a[6]  = mk(4'b0000, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_a[7]  = mk(4'b0000, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_a[8]  = mk(4'b0000, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_a[9]  = mk(4'b0101, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tab_a[10] = mk(4'b0000, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tab_a[11] = mk(4'b0000, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_a[12] = mk(4'b0000, 1'b0, 4'b0101, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_a[13] = mk(4'b0000, 1'b0, 4'b0101, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tab_a[14] = mk(4'b0000, 1'b0, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tab_a[15] = mk(4'b0000, 1'b0, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // n=4 hold=2: word 0110, then word 0000 with din_valid/din=F toggled mid-scan
    tab_b[0]  = mk(4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab_b[1]  = mk(4'b0000, 1'b0, 4'b0110, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[2]  = mk(4'b0000, 1'b0, 4'b0110, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[3]  = mk(4'b0000, 1'b0, 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_b[4]  = mk(4'b0000, 1'b0, 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_b[5]  = mk(4'b0000, 1'b0, 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_b[6]  = mk(4'b0000, 1'b0, 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tab_b[7]  = mk(4'b0000, 1'b0, 4'b0110, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tab_b[8]  = mk(4'b0000, 1'b0, 4'b0110, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tab_b[9]  = mk(4'b0000, 1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab_b[10] = mk(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[11] = mk(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[12] = mk(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[13] = mk(4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[14] = mk(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[15] = mk(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab_b[16] = mk(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tab_b[17] = mk(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tab_b[18] = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab_b[19] = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset state on every instance
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a rdy", bus_a.din_ready, 0);
    chk("rst a sv", bus_a.sv, 0);
    chk("rst a i", bus_a.i, 0);
    chk("rst a s", bus_a.s, 0);
    chk("rst a last", bus_a.last, 0);
    chk("rst a done", bus_a.done, 0);
    chk("rst b rdy", bus_b.din_ready, 0);
    chk("rst c rdy", bus_c.din_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      bus_a.din = tab_a[k].din;
      bus_a.din_valid = tab_a[k].vld;
      @(negedge clk);
      chk($sformatf("A[%0d] i", k), bus_a.i, tab_a[k].i);
      chk($sformatf("A[%0d] s", k), bus_a.s, tab_a[k].s);
      chk($sformatf("A[%0d] sv", k), bus_a.sv, tab_a[k].sv);
      chk($sformatf("A[%0d] last", k), bus_a.last, tab_a[k].last);
      chk($sformatf("A[%0d] rdy", k), bus_a.din_ready, tab_a[k].rdy);
      chk($sformatf("A[%0d] done", k), bus_a.done, tab_a[k].done);
      chk($sformatf("A[%0d] y", k), y4(bus_a.i, bus_a.s), tab_a[k].y);
      @(posedge clk); #1;
    end
    bus_a.din_valid = 1'b0;

    for (int k = 0; k < 20; k++) begin
      bus_b.din = tab_b[k].din;
      bus_b.din_valid = tab_b[k].vld;
      @(negedge clk);
      chk($sformatf("B[%0d] i", k), bus_b.i, tab_b[k].i);
      chk($sformatf("B[%0d] s", k), bus_b.s, tab_b[k].s);
      chk($sformatf("B[%0d] sv", k), bus_b.sv, tab_b[k].sv);
      chk($sformatf("B[%0d] last", k), bus_b.last, tab_b[k].last);
      chk($sformatf("B[%0d] rdy", k), bus_b.din_ready, tab_b[k].rdy);
      chk($sformatf("B[%0d] done", k), bus_b.done, tab_b[k].done);
      chk($sformatf("B[%0d] y", k), y4(bus_b.i, bus_b.s), tab_b[k].y);
      @(posedge clk); #1;
    end
    bus_b.din_valid = 1'b0;

    // n=3: select must go 0,1,2 and straight back to 0
    bus_c.din = 3'b101;
    bus_c.din_valid = 1'b1;
    @(negedge clk);
    chk("C accept rdy", bus_c.din_ready, 1);
    @(posedge clk); #1;
    bus_c.din_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("C[%0d] s", j), bus_c.s, j);
      chk($sformatf("C[%0d] sv", j), bus_c.sv, 1);
      chk($sformatf("C[%0d] last", j), bus_c.last, (j == 2) ? 1 : 0);
      chk($sformatf("C[%0d] y", j), y3(bus_c.i, bus_c.s), (j == 1) ? 0 : 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("C end s", bus_c.s, 0);
    chk("C end sv", bus_c.sv, 0);
    chk("C end done", bus_c.done, 1);
    @(posedge clk); #1;

    // random run on dut_b against the elapsed-time model
    m_busy = 1'b0; m_t = 0; m_word = 4'd0; m_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int         es;
      bit         erdy, acc, nd;
      logic [3:0] rd;
      bit         rv;
      rd = 4'($urandom);
      rv = ($urandom_range(0, 2) != 0);
      bus_b.din = rd;
      bus_b.din_valid = rv;
      es   = m_busy ? (m_t / HB) : 0;
      erdy = !m_busy || (m_t == NB * HB - 1);
      @(negedge clk);
      chk($sformatf("R[%0d] i", c), bus_b.i, m_word);
      chk($sformatf("R[%0d] s", c), bus_b.s, es);
      chk($sformatf("R[%0d] sv", c), bus_b.sv, m_busy);
      chk($sformatf("R[%0d] last", c), bus_b.last, (m_busy && es == NB - 1) ? 1 : 0);
      chk($sformatf("R[%0d] rdy", c), bus_b.din_ready, erdy);
      chk($sformatf("R[%0d] done", c), bus_b.done, m_done);
      @(posedge clk);
      acc = rv && erdy;
      nd  = m_busy && (m_t == NB * HB - 1);
      if (acc) begin
        m_word = rd; m_busy = 1'b1; m_t = 0;
      end else if (m_busy) begin
        if (m_t == NB * HB - 1) m_busy = 1'b0;
        else m_t++;
      end
      m_done = nd;
      #1;
    end
    bus_b.din_valid = 1'b0;

    // asynchronous reset in the middle of a scan on dut_a
    bus_a.din = 4'b1111;
    bus_a.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.din_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("X pre s", bus_a.s, 2);
    chk("X pre sv", bus_a.sv, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("X rst i", bus_a.i, 0);
    chk("X rst s", bus_a.s, 0);
    chk("X rst sv", bus_a.sv, 0);
    chk("X rst rdy", bus_a.din_ready, 0);
    chk("X rst last", bus_a.last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("X idle[%0d] done", j), bus_a.done, 0);
      chk($sformatf("X idle[%0d] rdy", j), bus_a.din_ready, 1);
      @(posedge clk); #1;
    end
    bus_a.din = 4'b0011;
    bus_a.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.din_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("X scan[%0d] s", j), bus_a.s, j);
      chk($sformatf("X scan[%0d] sv", j), bus_a.sv, 1);
      chk($sformatf("X scan[%0d] y", j), y4(bus_a.i, bus_a.s), (j < 2) ? 1 : 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("X end done", bus_a.done, 1);
    chk("X end sv", bus_a.sv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
